// File: rtl/param_updown_counter.sv
// Up/down counter with programmable modulus, variable step and parallel load.
// Wraps modulo MAX_VAL+1 or clamps at 0/MAX_VAL, with one-cycle over/underflow pulses.
module param_updown_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       direction,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             at_zero,
  output logic             at_max,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAXW = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MODW = MAXW + 1'b1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   up_wrap;
  logic [WIDTH:0]   dn_wrap;
  logic             do_up;
  logic             do_dn;

  assign s      = (step > MAXV) ? MAXV : step;
  assign ld_val = (load_value > MAXV) ? MAXV : load_value;
  assign sum    = {1'b0, count_q} + {1'b0, s};
  assign up_wrap = sum - MODW;
  assign dn_wrap = {1'b0, count_q} + MODW - {1'b0, s};

  // A zero effective step is treated as hold so no flag can fire.
  assign do_up = !load && enable && (direction == 2'b01) && (s != '0);
  assign do_dn = !load && enable && (direction == 2'b11) && (s != '0);

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    unique case (1'b1)
      load: begin
        count_d = ld_val;
      end
      do_up: begin
        if (sum <= MAXW) begin
          count_d = sum[WIDTH-1:0];
        end else begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? MAXV : up_wrap[WIDTH-1:0];
        end
      end
      do_dn: begin
        if (s <= count_q) begin
          count_d = count_q - s;
        end else begin
          unf_d   = 1'b1;
          count_d = SATURATE ? '0 : dn_wrap[WIDTH-1:0];
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign at_zero   = (count_q == '0);
  assign at_max    = (count_q == MAXV);

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised up/down counter with programmable modulus, variable step, parallel load, and selectable wrap or saturate behaviour. It generalises the fixed 4-bit up/down counter. Two-bit direction control is kept: 01 counts up, 11 counts down, anything else holds. It sits in the same control datapath and serves as a general event, credit or address counter wherever a fixed power-of-two range is not enough.

## Interface
- WIDTH, 8: counter, load-value and step width in bits (≥ 2).
- MAX_VAL, 2**WIDTH-1: terminal value. Count range is 0..MAX_VAL (modulus MAX_VAL+1). Must satisfy 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- SATURATE, 0: 0 means wrap modulo MAX_VAL+1; 1 means clamp at 0 / MAX_VAL.

Ports:
- clk, input, 1: rising-edge clock; sole clock.
- reset, input, 1: synchronous, active-high; highest priority.
- enable, input, 1: count qualifier. When 0, the count holds unless load is asserted.
- direction, input, 2: 01 = up, 11 = down, 00/10 = hold.
- load, input, 1: parallel load request.
- load_value, input, WIDTH: value for load.
- step, input, WIDTH: increment/decrement magnitude per counting cycle.
- count, output, WIDTH: registered count value.
- at_zero, output, 1: count == 0 (combinational from the count register).
- at_max, output, 1: count == MAX_VAL (combinational from the count register).
- overflow, output, 1: registered one-cycle pulse. An up step exceeded MAX_VAL.
- underflow, output, 1: registered one-cycle pulse. A down step went below 0.

## Operation
- Priority each rising clk edge: reset > load > (enable && direction ∈ {01,11}) > hold.
- reset: count = 0, overflow = 0, underflow = 0. The outputs after the reset edge are therefore at_zero = 1 and at_max = 0 (at_max = 1 only if MAX_VAL = 0, which is illegal).
- load: count = min(load_value, MAX_VAL). overflow and underflow are both 0. direction and step are ignored.
- Effective step s = min(step, MAX_VAL). If s = 0, count holds and no flag is raised.
- Up counting. Compute the sum count + s in WIDTH+1 bits.
  - If sum ≤ MAX_VAL: count = sum.
  - Else if SATURATE = 0: count = sum − (MAX_VAL+1), and overflow = 1.
  - Else (SATURATE = 1): count = MAX_VAL, and overflow = 1. This includes the case where count is already MAX_VAL, so overflow pulses on every cycle of a sustained attempt to exceed MAX_VAL.
- Down counting.
  - If s ≤ count: count = count − s.
  - Else if SATURATE = 0: count = count + (MAX_VAL+1) − s (computed in WIDTH+1 bits), and underflow = 1.
  - Else (SATURATE = 1): count = 0, and underflow = 1. The same repeat-pulse rule applies when count is already 0.
- overflow and underflow are never asserted together. On any edge that did not flag, they return to 0.
- direction 00/10 or enable = 0: count holds and both flags are 0.
- The count never leaves 0..MAX_VAL, whatever the inputs.

## Timing
- Latency is one cycle. Inputs sampled at edge N determine count, overflow and underflow after edge N.
- overflow/underflow rise in the same cycle that count first shows the wrapped or saturated value. They last exactly one cycle per offending edge.
- at_zero and at_max track count with no additional delay.
- Reset mid-count: the value is discarded at the next edge, regardless of load or enable. There is no partial update.
- Load and count requested together: the load wins and no flag is raised.
- Inputs are assumed synchronous to clk. No internal input registering.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9.
- Reset/basic (SATURATE=0): reset 1 cycle, then enable=1, direction=01, step=1 for 12 cycles. Required: count 1..9, 0, 1, 2. overflow is high only in the cycle count shows 0. at_max is high while count = 9.
- Wrap-down with step (SATURATE=0): load 2, then direction=11, step=3. Required: count becomes 9 (2+10−3) with underflow=1. The next edge gives 6 with underflow=0.
- Saturate (SATURATE=1): load 8, then direction=01, step=4 for 3 cycles. Required: count 9, 9, 9, with overflow=1 on all three edges. Then direction=11, step=15 (clamped to 9) gives count 0, underflow=0, since 9−9 does not go below 0.
- Load clamp and priority: load=1, load_value=14, enable=1, direction=01. Required: count=9 and no flag. Then reset=1 together with load=1 gives count=0 and at_zero=1.
- Hold conditions: count=5. Apply direction=00, then 10, then enable=0 with direction=01, then step=0 with direction=11. Required: count stays 5 on every edge and both flags stay 0.
- Mid-operation reset: count up to 7, then assert reset for one cycle while direction=01. Required: count=0 the next cycle, with counting resuming at 1.
